// File: rtl/router_pkt_tx.sv
// Packet transmitter feeding the 1x3 router input port.
// Buffers up to 63 payload bytes, then sends header, payload and parity.
module router_pkt_tx #(
  parameter int GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       wr_full,
  input  logic       start,
  input  logic [1:0] addr,
  input  logic       corrupt_par,
  input  logic       busy,
  input  logic       router_err,
  output logic [7:0] data_out,
  output logic       pkt_valid,
  output logic       tx_idle,
  output logic       done,
  output logic       req_err,
  output logic       pkt_err
);

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    PAYLOAD,
    PARITY,
    GAP
  } state_t;

  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  state_t     state;
  logic [7:0] mem [63];
  logic [5:0] count;
  logic [5:0] rd_ptr;
  logic [7:0] parity;
  logic [7:0] par_next;
  logic       cor;
  logic [7:0] gap_cnt;
  logic       write_ok;

  // Parity including the byte currently presented to the router.
  assign par_next = parity ^ data_out;

  assign write_ok = (state == IDLE) && wr_en && !start
                    && (count != 6'd63);

  // Payload storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (write_ok) mem[count] <= wr_data;
  end

  // Transmit FSM with registered outputs computed for the next state.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      count     <= '0;
      rd_ptr    <= '0;
      parity    <= '0;
      cor       <= 1'b0;
      gap_cnt   <= '0;
      data_out  <= '0;
      pkt_valid <= 1'b0;
      tx_idle   <= 1'b1;
      done      <= 1'b0;
      req_err   <= 1'b0;
      pkt_err   <= 1'b0;
      wr_full   <= 1'b0;
    end else begin
      done    <= 1'b0;
      req_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (count != 6'd0 && addr != 2'b11) begin
              state     <= HEADER;
              data_out  <= {count, addr};
              pkt_valid <= 1'b1;
              tx_idle   <= 1'b0;
              cor       <= corrupt_par;
              pkt_err   <= 1'b0;
              rd_ptr    <= '0;
              parity    <= '0;
            end else begin
              req_err <= 1'b1;
            end
          end else if (write_ok) begin
            count   <= count + 6'd1;
            wr_full <= (count == 6'd62);
          end
        end
        HEADER: begin
          if (!busy) begin
            parity   <= par_next;
            data_out <= mem[rd_ptr];
            state    <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (!busy) begin
            parity <= par_next;
            rd_ptr <= rd_ptr + 6'd1;
            if (rd_ptr == count - 6'd1) begin
              state     <= PARITY;
              pkt_valid <= 1'b0;
              data_out  <= par_next ^ {7'b0, cor};
            end else begin
              data_out <= mem[rd_ptr + 6'd1];
            end
          end
        end
        PARITY: begin
          if (!busy) begin
            done     <= 1'b1;
            count    <= '0;
            wr_full  <= 1'b0;
            data_out <= '0;
            gap_cnt  <= '0;
            state    <= GAP;
          end
        end
        GAP: begin
          if (router_err) pkt_err <= 1'b1;
          if (gap_cnt == GAP_LAST) begin
            state   <= IDLE;
            tx_idle <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Bench for router_pkt_tx: scoreboard of expected router bytes,
// one task per scenario, inputs driven and outputs sampled on negedge.
module tb_router_pkt_tx;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       start = 1'b0;
  logic [1:0] addr = 2'b00;
  logic       corrupt_par = 1'b0;
  logic       busy = 1'b0;
  logic       router_err = 1'b0;
  logic       wr_full;
  logic [7:0] data_out;
  logic       pkt_valid;
  logic       tx_idle;
  logic       done;
  logic       req_err;
  logic       pkt_err;

  int vec = 0;
  int miss = 0;

  logic [7:0] model_buf [$];
  logic [8:0] exp_q [$];

  always #5 clk = ~clk;

  router_pkt_tx #(.GAP_CYCLES(2)) dut (
    .clk(clk),
    .rstn(rstn),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .wr_full(wr_full),
    .start(start),
    .addr(addr),
    .corrupt_par(corrupt_par),
    .busy(busy),
    .router_err(router_err),
    .data_out(data_out),
    .pkt_valid(pkt_valid),
    .tx_idle(tx_idle),
    .done(done),
    .req_err(req_err),
    .pkt_err(pkt_err)
  );

  task automatic wr_byte(input logic [7:0] b);
    wr_en = 1'b1;
    wr_data = b;
    @(negedge clk);
    wr_en = 1'b0;
    if (model_buf.size() < 63) model_buf.push_back(b);
  endtask

  task automatic push_expected(input logic [1:0] a, input logic c);
    logic [7:0] h;
    logic [7:0] p;
    h = {6'(model_buf.size()), a};
    p = h;
    exp_q.push_back({1'b1, h});
    foreach (model_buf[i]) begin
      exp_q.push_back({1'b1, model_buf[i]});
      p = p ^ model_buf[i];
    end
    exp_q.push_back({1'b0, p ^ {7'b0, c}});
    model_buf.delete();
  endtask

  task automatic do_start(input logic [1:0] a, input logic c,
                          input logic acc);
    start = 1'b1;
    addr = a;
    corrupt_par = c;
    if (acc) push_expected(a, c);
    @(negedge clk);
    start = 1'b0;
    corrupt_par = 1'b0;
    vec++;
    if (req_err !== !acc) begin
      miss++;
      $display("FAIL start_req_err got %b want %b", req_err, !acc);
    end
    vec++;
    if (tx_idle !== !acc) begin
      miss++;
      $display("FAIL start_tx_idle got %b want %b", tx_idle, !acc);
    end
  endtask

  task automatic transmit(input int ia, input int la, input int ib,
                          input int lb, input int want);
    int cyc;
    int n;
    logic [8:0] e;
    int s;
    cyc = 0;
    n = exp_q.size();
    for (int k = 0; k < n; k++) begin
      e = exp_q.pop_front();
      s = (k == ia) ? la : (k == ib) ? lb : 0;
      for (int j = 0; j <= s; j++) begin
        vec++;
        if ({pkt_valid, data_out} !== e) begin
          miss++;
          $display("FAIL byte%0d_cyc%0d got %h want %h",
                   k, j, {pkt_valid, data_out}, e);
        end
        busy = (j < s);
        @(negedge clk);
        cyc++;
      end
    end
    busy = 1'b0;
    vec++;
    if (cyc !== want) begin
      miss++;
      $display("FAIL tx_cycles got %0d want %0d", cyc, want);
    end
  endtask

  task automatic finish_gap(input logic err);
    vec++;
    if (done !== 1'b1) begin
      miss++;
      $display("FAIL done_pulse got %b want 1", done);
    end
    vec++;
    if (tx_idle !== 1'b0) begin
      miss++;
      $display("FAIL gap_not_idle got %b want 0", tx_idle);
    end
    start = 1'b1;
    addr = 2'b00;
    @(negedge clk);
    start = 1'b0;
    router_err = err;
    vec++;
    if (done !== 1'b0) begin
      miss++;
      $display("FAIL done_single got %b want 0", done);
    end
    vec++;
    if (req_err !== 1'b0) begin
      miss++;
      $display("FAIL gap_start_ignored got %b want 0", req_err);
    end
    vec++;
    if (tx_idle !== 1'b0) begin
      miss++;
      $display("FAIL gap_len got %b want 0", tx_idle);
    end
    @(negedge clk);
    router_err = 1'b0;
    vec++;
    if (tx_idle !== 1'b1) begin
      miss++;
      $display("FAIL gap_end_idle got %b want 1", tx_idle);
    end
    vec++;
    if (pkt_err !== err) begin
      miss++;
      $display("FAIL pkt_err got %b want %b", pkt_err, err);
    end
  endtask

  task automatic check_reset_outs(input string tag);
    vec++;
    if ({data_out, pkt_valid, tx_idle, done, req_err, pkt_err, wr_full}
        !== {8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      miss++;
      $display("FAIL %s got %h/%b%b%b%b%b%b want 00/010000", tag,
               data_out, pkt_valid, tx_idle, done, req_err,
               pkt_err, wr_full);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outs("reset");
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reject();
    do_start(2'd0, 1'b0, 1'b0);
    @(negedge clk);
    vec++;
    if (req_err !== 1'b0) begin
      miss++;
      $display("FAIL req_err_pulse got %b want 0", req_err);
    end
    wr_byte(8'h44);
    wr_byte(8'h55);
    do_start(2'd3, 1'b0, 1'b0);
    do_start(2'd0, 1'b0, 1'b1);
    vec++;
    if (data_out !== 8'h08) begin
      miss++;
      $display("FAIL reject_count_kept got %h want 08", data_out);
    end
    transmit(-1, 0, -1, 0, 4);
    finish_gap(1'b0);
  endtask

  task automatic test_basic();
    wr_byte(8'h11);
    wr_byte(8'h22);
    wr_byte(8'h33);
    wr_en = 1'b1;
    wr_data = 8'hEE;
    do_start(2'd1, 1'b0, 1'b1);
    wr_en = 1'b0;
    vec++;
    if (data_out !== 8'h0D) begin
      miss++;
      $display("FAIL basic_header got %h want 0d", data_out);
    end
    transmit(-1, 0, -1, 0, 5);
    finish_gap(1'b0);
  endtask

  task automatic test_back_to_back();
    wr_byte(8'h11);
    wr_byte(8'h22);
    wr_byte(8'h33);
    do_start(2'd1, 1'b0, 1'b1);
    transmit(2, 3, 4, 2, 10);
    finish_gap(1'b0);
  endtask

  task automatic test_full();
    for (int i = 0; i < 62; i++) wr_byte(8'hA5);
    vec++;
    if (wr_full !== 1'b0) begin
      miss++;
      $display("FAIL full_at_62 got %b want 0", wr_full);
    end
    wr_byte(8'hA5);
    vec++;
    if (wr_full !== 1'b1) begin
      miss++;
      $display("FAIL full_at_63 got %b want 1", wr_full);
    end
    wr_byte(8'hA5);
    vec++;
    if (wr_full !== 1'b1) begin
      miss++;
      $display("FAIL full_at_64 got %b want 1", wr_full);
    end
    do_start(2'd2, 1'b0, 1'b1);
    vec++;
    if (data_out !== 8'hFE) begin
      miss++;
      $display("FAIL full_header got %h want fe", data_out);
    end
    transmit(-1, 0, -1, 0, 65);
    finish_gap(1'b0);
  endtask

  task automatic test_corrupt();
    wr_byte(8'h11);
    wr_byte(8'h22);
    wr_byte(8'h33);
    do_start(2'd1, 1'b1, 1'b1);
    transmit(-1, 0, -1, 0, 5);
    finish_gap(1'b1);
    wr_byte(8'h01);
    do_start(2'd0, 1'b0, 1'b1);
    vec++;
    if (pkt_err !== 1'b0) begin
      miss++;
      $display("FAIL pkt_err_clear got %b want 0", pkt_err);
    end
    transmit(-1, 0, -1, 0, 3);
    finish_gap(1'b0);
  endtask

  task automatic test_mid_reset();
    wr_byte(8'h11);
    wr_byte(8'h22);
    wr_byte(8'h33);
    do_start(2'd0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    vec++;
    if (data_out !== 8'h22) begin
      miss++;
      $display("FAIL mid_byte2 got %h want 22", data_out);
    end
    rstn = 1'b0;
    @(negedge clk);
    check_reset_outs("mid_reset");
    rstn = 1'b1;
    exp_q.delete();
    model_buf.delete();
    wr_byte(8'h5A);
    do_start(2'd0, 1'b0, 1'b1);
    vec++;
    if (data_out !== 8'h04) begin
      miss++;
      $display("FAIL fresh_header got %h want 04", data_out);
    end
    transmit(-1, 0, -1, 0, 3);
    finish_gap(1'b0);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_reject();
    test_basic();
    test_back_to_back();
    test_full();
    test_corrupt();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
